alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Operand-fetch/issue stage directly upstream of the 4-bit combinational ALU.
//  Accepts instructions over a valid/ready handshake and holds an 8-entry register file.
//  Drives registered A/B/select into the ALU, captures F/cout, and writes the result back to the register file.
//  Turns the ALU into a minimal 3-cycle-per-instruction execute datapath.
// PARAMETERS
//  WIDTH  4  data width; must match ALU operand width
//  NREGS  8  register count; AW = $clog2(NREGS) = 3 (localparam)
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  instr_valid    in   1      instruction present
//  instr_ready    out  1      stage can accept
//  instr_op       in   3      ALU select code, passed to alu_sel
//  instr_dst      in   AW     destination register
//  instr_srca     in   AW     source A register
//  instr_srcb     in   AW     source B register
//  instr_use_imm  in   1      1: B operand = instr_imm instead of reg[srcb]
//  instr_imm      in   WIDTH  immediate B operand
//  alu_a          out  WIDTH  ALU operand A (registered)
//  alu_b          out  WIDTH  ALU operand B (registered)
//  alu_sel        out  3      ALU control C (registered)
//  alu_f          in   WIDTH  ALU result
//  alu_cout       in   1      ALU adder carry-out
//  wb_valid       out  1      writeback occurring this cycle
//  wb_addr        out  AW     writeback register
//  wb_data        out  WIDTH  writeback data
//  dbg_addr       in   AW     debug read address
//  dbg_data       out  WIDTH  reg[dbg_addr], combinational
// BEHAVIOUR
//  Reset: state=IDLE; all registers, alu_a/alu_b/alu_sel, wb_* and flags = 0.
//    Reset is legal in any state; a pending instruction is dropped, with no partial writeback.
//  State machine: IDLE -> EXEC -> WB -> IDLE. instr_ready = (state==IDLE).
//  Edge T0 (IDLE, valid&ready) latches the instruction:
//    alu_a <= reg[srca]; alu_b <= use_imm ? imm : reg[srcb]; alu_sel <= op; dst latched; state EXEC.
//  EXEC: ALU evaluates combinationally.
//    Edge T1: result_q <= alu_f; state WB.
//  WB: wb_valid=1, wb_addr=dst, wb_data=result_q.
//    Edge T2: reg[dst] <= result_q; state IDLE.
//  Timing: next accept is at T3 at the earliest, so no read-after-write hazard and no forwarding is needed.
//    Throughput is 1 instruction per 3 cycles.
//  Register r0 reads as 0 always; writes to r0 are discarded, but the wb_* pulse still asserts.
//  Result width: the result is the WIDTH LSBs of F; overflow wraps (e.g. 5*3=15, 7+9=0).
//  Unary ops 000/001: B is still read and driven; the ALU ignores it.
//  instr_valid low in IDLE: stay in IDLE, no register change, alu_* outputs hold their last values.
//  instr_* fields are sampled only at the accept edge and may change freely afterwards.
//  alu_f and alu_cout are sampled only at T1.
// CONFIGURATION
//  ALU_FLAGS_EN defined:
//    Adds outputs flag_z, flag_c (1 bit each, reset 0), updated at T1 only.
//    flag_z <= (alu_f==0).
//    flag_c <= alu_cout when alu_sel==ADD (010), else 0.
//    Flags hold their value between instructions.
//  ALU_FLAGS_EN undefined: flag ports and logic are absent; alu_cout is unused.
// STRUCTURE
//  Shared package alu_defs:
//    OP_TCA=000, OP_TCB=001, OP_ADD=010, OP_SUB=011, OP_AND=100, OP_OR=101, OP_MUL=110, OP_XOR=111.
//    State encoding ST_IDLE/ST_EXEC/ST_WB.
//  Sub-module reg_file: NREGS x WIDTH, 2 async read ports + dbg read port, 1 sync write port, async clear on rst_n.
//    r0 is forced to zero inside reg_file.
//  Top level holds the FSM, operand/result registers, and the flag logic.
// TESTING (bench instantiates alu_issue_stage + real ALU)
//  1 Reset then idle:
//    Expect instr_ready=1, alu_*=0, wb_valid=0, dbg_data=0 for all addresses.
//  2 Load and add:
//    Load r1=5, r2=3 via OR-imm from r0 (op 101, imm 5 / 3).
//    Then ADD dst=r3, srca=r1, srcb=r2.
//    Expect wb_data=8 with wb_valid at T1+1; r3 reads 8; instr_ready low for exactly 2 cycles per instr.
//  3 Arithmetic ops from r1=5, r2=3:
//    SUB -> r4=2; MUL -> r5=15; XOR -> r6=6; TCA of r1 -> r7=11 (1011).
//  4 Wrap and flags (ALU_FLAGS_EN):
//    r1=7, imm 9, ADD -> wb_data=0, flag_z=1, flag_c=1.
//    Next AND 5&3 -> 1, flag_z=0, flag_c=0.
//  5 r0 handling:
//    ADD dst=r0 with 5+3 -> wb_valid pulses with data 8, but dbg_data(r0) stays 0.
//  6 Reset mid-op:
//    Assert rst_n=0 during EXEC -> immediate IDLE, all registers 0, no writeback pulse.
//    After release, the first instruction completes normally.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU issue stage: ALU select codes and FSM states.
package alu_defs;

  typedef enum logic [2:0] {
    OP_TCA = 3'b000,
    OP_TCB = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_MUL = 3'b110,
    OP_XOR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// reg_file: NREGS x WIDTH register file, two async read ports plus a debug
// read port, one synchronous write port, async clear. r0 always reads zero.
module reg_file
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 8,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [WIDTH-1:0] o_rdata_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_b,
  input  logic [AW-1:0]    i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

  logic [WIDTH-1:0] r_mem [NREGS];

  // Storage: async clear, synchronous write; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-fetch/issue stage feeding a 4-bit combinational ALU.
// Accept (IDLE) -> EXEC (ALU evaluates, result captured) -> WB (write back).
// Optional macro ALU_FLAGS_EN adds zero/carry flag outputs flag_z/flag_c.
module alu_issue_stage
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 8,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [AW-1:0]    instr_dst,
  input  logic [AW-1:0]    instr_srca,
  input  logic [AW-1:0]    instr_srcb,
  input  logic             instr_use_imm,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
`ifdef ALU_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_c
`endif
);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_accept;
  logic             w_wb_valid;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_sel;
  logic [AW-1:0]    r_dst;
  logic [WIDTH-1:0] r_result;

  assign w_accept   = instr_valid && (r_state == ST_IDLE);
  assign w_wb_valid = (r_state == ST_WB);

  reg_file #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_reg_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_wb_valid),
    .i_waddr    (r_dst),
    .i_wdata    (r_result),
    .i_raddr_a  (instr_srca),
    .o_rdata_a  (w_rd_a),
    .i_raddr_b  (instr_srcb),
    .o_rdata_b  (w_rd_b),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state: fixed three-cycle sequence per accepted instruction.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (instr_valid) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_WB;
      ST_WB:   w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand latch: sample register reads / immediate only at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_dst     <= '0;
    end else if (w_accept) begin
      r_alu_a   <= w_rd_a;
      r_alu_b   <= instr_use_imm ? instr_imm : w_rd_b;
      r_alu_sel <= instr_op;
      r_dst     <= instr_dst;
    end
  end

  // Result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_result <= '0;
    else if (r_state == ST_EXEC) r_result <= alu_f;
  end

`ifdef ALU_FLAGS_EN
  logic r_flag_z;
  logic r_flag_c;

  // Flags update with the result capture and hold between instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_flag_z <= (alu_f == '0);
      r_flag_c <= (r_alu_sel == OP_ADD) ? alu_cout : 1'b0;
    end
  end

  assign flag_z = r_flag_z;
  assign flag_c = r_flag_c;
`else
  logic w_unused_cout;
  assign w_unused_cout = alu_cout;
`endif

  assign instr_ready = (r_state == ST_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_sel     = r_alu_sel;
  assign wb_valid    = w_wb_valid;
  assign wb_addr     = r_dst;
  assign wb_data     = r_result;

endmodule
